chord_song_reader: RTL and testbench

Note sequencer that feeds the three-voice chord player. It walks a song ROM and issues one note per `new_note` pulse, but only while the chord player reports a free voice on `player_ready`. A per-entry beat delay decides whether the next note stacks onto the current chord (delay 0) or starts after a number of beats. It sits between the top-level song/play controls and the chord player, as the producer side of the note/duration/new_note/player_ready handshake.

---
 rtl/song_pkg.sv | 25 ++
 rtl/chord_song_rom.sv | 51 +++++
 rtl/chord_song_reader.sv | 137 +++++++++++++
 tb/tb_chord_song_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared types and ROM word layout for the chord song sequencer.
package song_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_DELAY,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam int WORD_BITS = 16;
  localparam int NOTE_MSB  = 15;
  localparam int NOTE_LSB  = 10;
  localparam int DUR_MSB   = 9;
  localparam int DUR_LSB   = 4;
  localparam int DELAY_MSB = 3;
  localparam int DELAY_LSB = 0;

  localparam logic [WORD_BITS-1:0] END_MARKER = 16'h0000;
  localparam int SONG_LEN = 32;

endpackage

// File: rtl/chord_song_rom.sv
// Song ROM with synchronous read; data appears the cycle after the address.
module chord_song_rom
  import song_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
) (
  input  logic                          clk,
  input  logic [SONG_BITS+IDX_BITS-1:0] addr,
  output logic [WORD_BITS-1:0]          data
);

  localparam int AW = SONG_BITS + IDX_BITS;

  // Song table: 0 = C-E-G stacked chord, 1 = 32-note run with no marker,
  // 2 = short phrase with a rest, 3 = empty song.
  function automatic logic [WORD_BITS-1:0] song_word(input logic [AW-1:0] a);
    logic [SONG_BITS-1:0] s;
    logic [IDX_BITS-1:0]  i;
    logic [WORD_BITS-1:0] w;
    s = a[AW-1:IDX_BITS];
    i = a[IDX_BITS-1:0];
    w = END_MARKER;
    case (int'(s))
      0: begin
        case (int'(i))
          0:       w = {6'd24, 6'd8, 4'd0};
          1:       w = {6'd28, 6'd8, 4'd0};
          2:       w = {6'd31, 6'd8, 4'd4};
          default: w = END_MARKER;
        endcase
      end
      1:       w = {6'(i) + 6'd10, 6'(i) + 6'd1, 4'd0};
      2: begin
        case (int'(i))
          0:       w = {6'd40, 6'd4, 4'd1};
          1:       w = {6'd0,  6'd2, 4'd0};
          2:       w = {6'd45, 6'd3, 4'd0};
          default: w = END_MARKER;
        endcase
      end
      default: w = END_MARKER;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    data <= song_word(addr);
  end

endmodule

// File: rtl/chord_song_reader.sv
// Walks the song ROM and hands notes to the chord player one new_note at a time.
//
// state   | meaning
// IDLE    | idx held at 0, waiting for play; latches song on exit
// FETCH   | ROM address {song_q, idx} presented
// DECODE  | ROM word captured; end marker ends the song
// ISSUE   | waits for play and player_ready, then issues the note
// DELAY   | counts beats (only while playing) before the next fetch
// ADVANCE | steps idx, or ends the song after the last entry
// DONE    | song_done high until play drops
module chord_song_reader
  import song_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song,
  input  logic                 beat,
  input  logic                 player_ready,
  output logic [5:0]           note,
  output logic [5:0]           duration,
  output logic                 new_note,
  output logic                 song_done
);

  state_t                  state, state_d;
  logic [IDX_BITS-1:0]     idx;
  logic [SONG_BITS-1:0]    song_q;
  logic [WORD_BITS-1:0]    word_q;
  logic [WORD_BITS-1:0]    rom_data;
  logic [3:0]              delay_cnt;
  logic                    issue, idx_clr, idx_inc, latch_song, cnt_dec, word_ld;
  logic                    song_change;

  chord_song_rom #(
    .SONG_BITS (SONG_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_rom (
    .clk  (clk),
    .addr ({song_q, idx}),
    .data (rom_data)
  );

  assign song_change = (state != S_IDLE) && (state != S_DONE) && (song != song_q);

  always_comb begin
    state_d    = state;
    issue      = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    latch_song = 1'b0;
    cnt_dec    = 1'b0;
    word_ld    = 1'b0;
    // A song change aborts whatever is in flight, including a pending issue.
    if (song_change) begin
      state_d = S_IDLE;
      idx_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          idx_clr = 1'b1;
          if (play) begin
            latch_song = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          word_ld = 1'b1;
          state_d = (rom_data == END_MARKER) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: begin
          if (play && player_ready) begin
            issue   = 1'b1;
            state_d = (word_q[DELAY_MSB:DELAY_LSB] == 4'd0) ? S_ADVANCE : S_DELAY;
          end
        end
        S_DELAY: begin
          if (delay_cnt == 4'd0) begin
            state_d = S_ADVANCE;
          end else if (play && beat) begin
            cnt_dec = 1'b1;
            if (delay_cnt == 4'd1) state_d = S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (idx == IDX_BITS'(SONG_LEN - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_inc = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DONE: begin
          if (!play) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      song_q    <= '0;
      word_q    <= '0;
      delay_cnt <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
    end else begin
      state    <= state_d;
      new_note <= issue;
      if (latch_song) song_q <= song;
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + IDX_BITS'(1);
      end
      if (word_ld) word_q <= rom_data;
      if (issue) begin
        note      <= word_q[NOTE_MSB:NOTE_LSB];
        duration  <= word_q[DUR_MSB:DUR_LSB];
        delay_cnt <= word_q[DELAY_MSB:DELAY_LSB];
      end else if (cnt_dec) begin
        delay_cnt <= delay_cnt - 4'd1;
      end
    end
  end

  assign song_done = (state == S_DONE);

endmodule

// File: tb/tb_chord_song_reader.sv
// Directed bench for chord_song_reader: table of expected issues plus corner sequences.
module tb_chord_song_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       play = 1'b0;
  logic [1:0] song = 2'd0;
  logic       beat = 1'b0;
  logic       player_ready = 1'b0;
  logic [5:0] note, duration;
  logic       new_note, song_done;

  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;
  int   double_cnt = 0;
  logic prev_nn = 1'b0;

  always #5 clk = ~clk;

  chord_song_reader #(.SONG_BITS(2), .IDX_BITS(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .play         (play),
    .song         (song),
    .beat         (beat),
    .player_ready (player_ready),
    .note         (note),
    .duration     (duration),
    .new_note     (new_note),
    .song_done    (song_done)
  );

  typedef struct {
    logic [5:0] note;
    logic [5:0] dur;
    int         gap;
  } vec_t;

  vec_t tbl[38];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (new_note) begin
      pulse_cnt++;
      if (prev_nn) double_cnt++;
    end
    prev_nn = new_note;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
  endtask

  // Ticks until new_note is seen; n = number of ticks taken, 0 on timeout.
  task automatic wait_pulse(input int max, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 1; k <= max && !seen; k++) begin
      tick();
      if (new_note) begin
        seen = 1'b1;
        n = k;
      end
    end
  endtask

  task automatic run_table(input int first, input int count, input string tag);
    int n;
    for (int i = 0; i < count; i++) begin
      wait_pulse(20, n);
      check($sformatf("%s[%0d] gap", tag, i), n, tbl[first+i].gap);
      check($sformatf("%s[%0d] note", tag, i), int'(note), int'(tbl[first+i].note));
      check($sformatf("%s[%0d] duration", tag, i), int'(duration), int'(tbl[first+i].dur));
    end
  endtask

  initial begin
    int bad;
    int pc0;
    int n;

    // Expected issues: song 0 (0..2), song 2 after a switch (3..5), song 1 (6..37).
    tbl[0] = '{6'd24, 6'd8, 4};
    tbl[1] = '{6'd28, 6'd8, 4};
    tbl[2] = '{6'd31, 6'd8, 4};
    tbl[3] = '{6'd40, 6'd4, 4};
    tbl[4] = '{6'd0,  6'd2, 5};
    tbl[5] = '{6'd45, 6'd3, 4};
    for (int i = 0; i < 32; i++) tbl[6+i] = '{6'(i + 10), 6'(i + 1), 4};

    // Reset and idle with play low
    tick();
    tick();
    check("reset outputs", int'({note, duration, new_note, song_done}), 0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (new_note || song_done || note != 6'd0 || duration != 6'd0) bad++;
    end
    check("idle quiet cycles", bad, 0);

    // Song 0 chord stacking, then pause inside the final delay
    song = 2'd0;
    player_ready = 1'b1;
    play = 1'b1;
    run_table(0, 3, "song0");
    pc0 = pulse_cnt;
    pulse_beat();
    play = 1'b0;
    for (int i = 0; i < 5; i++) pulse_beat();
    check("paused song_done", int'(song_done), 0);
    play = 1'b1;
    pulse_beat();
    pulse_beat();
    tick(); tick(); tick(); tick();
    check("done before 4th beat", int'(song_done), 0);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
    tick();
    check("done too early", int'(song_done), 0);
    tick();
    check("song0 done", int'(song_done), 1);
    check("no pulse in delay", pulse_cnt - pc0, 0);
    play = 1'b0;
    tick();
    check("song_done falls", int'(song_done), 0);

    // Song switch 0 -> 2 mid-delay
    play = 1'b1;
    run_table(0, 3, "song0b");
    pulse_beat();
    song = 2'd2;
    tick();
    check("switch new_note", int'(new_note), 0);
    beat = 1'b1;
    run_table(3, 3, "song2");
    beat = 1'b0;
    tick();
    tick();
    check("song2 done early", int'(song_done), 0);
    tick();
    check("song2 done", int'(song_done), 1);
    play = 1'b0;
    tick();

    // Backpressure in ISSUE, then song change suppressing a ready issue
    song = 2'd2;
    player_ready = 1'b0;
    play = 1'b1;
    tick(); tick(); tick();
    pc0 = pulse_cnt;
    for (int i = 0; i < 50; i++) tick();
    check("backpressure pulses", pulse_cnt - pc0, 0);
    check("held note", int'(note), 45);
    check("held duration", int'(duration), 3);
    player_ready = 1'b1;
    tick();
    check("ready issue strobe", int'(new_note), 1);
    check("ready issue note", int'(note), 40);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick(); tick(); tick();
    song = 2'd3;
    tick();
    check("suppressed new_note", int'(new_note), 0);
    check("suppressed duration", int'(duration), 4);
    check("suppressed note", int'(note), 40);
    tick(); tick(); tick();
    check("empty song done", int'(song_done), 1);
    play = 1'b0;
    tick();

    // Full-length song without a marker
    song = 2'd1;
    play = 1'b1;
    pc0 = pulse_cnt;
    run_table(6, 32, "song1");
    check("song1 pulse count", pulse_cnt - pc0, 32);
    tick();
    check("song1 done", int'(song_done), 1);
    play = 1'b0;
    tick();
    check("song1 done falls", int'(song_done), 0);

    // Reset mid-song
    play = 1'b1;
    wait_pulse(20, n);
    check("pre-reset note", int'(note), 10);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("async reset outputs", int'({note, duration, new_note, song_done}), 0);
    play = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    pc0 = pulse_cnt;
    for (int i = 0; i < 10; i++) tick();
    check("post-reset pulses", pulse_cnt - pc0, 0);
    play = 1'b1;
    wait_pulse(20, n);
    check("restart gap", n, 4);
    check("restart note", int'(note), 10);
    play = 1'b0;
    tick();

    check("back-to-back pulses", double_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
